// File: rtl/countdown_timer_if.sv
// Control/status bundle for countdown_timer: the master drives commands and
// load_val, and the slave (the timer) returns count, busy and done.
interface countdown_timer_if #(
  parameter int unsigned N = 4
);
  logic         start;
  logic         pause;
  logic         abort;
  logic         reload_en;
  logic [N-1:0] load_val;
  logic [N-1:0] count;
  logic         busy;
  logic         done;

  modport master (
    output start, pause, abort, reload_en, load_val,
    input  count, busy, done
  );

  modport slave (
    input  start, pause, abort, reload_en, load_val,
    output count, busy, done
  );
endinterface

// File: rtl/countdown_timer.sv
// Programmable N-bit down-counting timer with pause, abort, restart and
// optional auto-reload; done pulses for one cycle on expiry.
module countdown_timer #(
  parameter int unsigned N = 4
) (
  input logic              clk,
  input logic              nrst,
  countdown_timer_if.slave bus
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t       state;
  logic [N-1:0] count_q;
  logic [N-1:0] reload_q;
  logic         busy_q;
  logic         done_q;

  // Priority per edge: abort > start > pause > decrement.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state    <= IDLE;
      count_q  <= N'(0);
      reload_q <= N'(0);
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.abort) begin
        state   <= IDLE;
        count_q <= N'(0);
        busy_q  <= 1'b0;
      end else if (bus.start) begin
        count_q  <= bus.load_val;
        reload_q <= bus.load_val;
        if (bus.load_val != N'(0)) begin
          state  <= RUN;
          busy_q <= 1'b1;
        end else begin
          // Zero-length timer expires immediately and never enters RUN.
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end else if (state == RUN && !bus.pause) begin
        if (count_q > N'(1)) begin
          count_q <= count_q - N'(1);
        end else begin
          done_q <= (count_q == N'(1));
          if (bus.reload_en && count_q == N'(1)) begin
            count_q <= reload_q;
          end else begin
            state   <= IDLE;
            count_q <= N'(0);
            busy_q  <= 1'b0;
          end
        end
      end
    end
  end

  assign bus.count = count_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed-vector bench for countdown_timer (N=4) with hand-computed expectations.
module tb_countdown_timer;

  logic clk = 1'b0;
  logic nrst;
  int   errors = 0;
  int   checks = 0;

  countdown_timer_if #(.N(4)) bus ();

  countdown_timer #(.N(4)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic expect3(input string tag, input int c, input int b, input int d);
    check({tag, "_count"}, int'(bus.count), c);
    check({tag, "_busy"},  int'(bus.busy),  b);
    check({tag, "_done"},  int'(bus.done),  d);
  endtask

  // Advance one clock and settle away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.start     = 1'b0;
    bus.pause     = 1'b0;
    bus.abort     = 1'b0;
    bus.reload_en = 1'b0;
    bus.load_val  = 4'd0;
  endtask

  task automatic do_start(input logic [3:0] v, input logic rl);
    bus.start     = 1'b1;
    bus.load_val  = v;
    bus.reload_en = rl;
    step();
    bus.start     = 1'b0;
  endtask

  initial begin
    idle_inputs();
    nrst = 1'b0;
    #12;
    expect3("rst_init", 0, 0, 0);
    nrst = 1'b1;
    step();

    // 1: asynchronous reset mid-countdown
    do_start(4'd7, 1'b0);
    expect3("pre_rst", 7, 1, 0);
    #2 nrst = 1'b0;
    #1 expect3("async_rst", 0, 0, 0);
    #2 nrst = 1'b1;
    step(); step();
    expect3("post_rst_idle", 0, 0, 0);

    // pause in IDLE has no effect
    bus.pause = 1'b1;
    step();
    expect3("idle_pause", 0, 0, 0);
    bus.pause = 1'b0;

    // 2: one-shot
    do_start(4'd5, 1'b0);
    expect3("os_load", 5, 1, 0);
    for (int i = 4; i >= 1; i--) begin
      step();
      expect3("os_dec", i, 1, 0);
    end
    step();
    expect3("os_expire", 0, 0, 1);
    step();
    expect3("os_after", 0, 0, 0);

    // 3: periodic, then drop reload_en
    do_start(4'd3, 1'b1);
    expect3("per_load", 3, 1, 0);
    step(); expect3("per_2", 2, 1, 0);
    step(); expect3("per_1", 1, 1, 0);
    step(); expect3("per_reload", 3, 1, 1);
    step(); expect3("per_2b", 2, 1, 0);
    step(); expect3("per_1b", 1, 1, 0);
    bus.reload_en = 1'b0;
    step(); expect3("per_end", 0, 0, 1);
    step(); expect3("per_idle", 0, 0, 0);

    // 4a: pause delays expiry
    do_start(4'd6, 1'b0);
    step(); step();
    expect3("pz_at4", 4, 1, 0);
    bus.pause = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      expect3("pz_hold", 4, 1, 0);
    end
    bus.pause = 1'b0;
    for (int i = 3; i >= 1; i--) begin
      step();
      expect3("pz_dec", i, 1, 0);
    end
    step(); expect3("pz_expire", 0, 0, 1);

    // 4b: restart abandons old countdown
    do_start(4'd6, 1'b0);
    step(); step(); step();
    expect3("rs_at3", 3, 1, 0);
    do_start(4'd2, 1'b0);
    expect3("rs_load", 2, 1, 0);
    step(); expect3("rs_1", 1, 1, 0);
    step(); expect3("rs_expire", 0, 0, 1);
    step(); expect3("rs_idle", 0, 0, 0);

    // 5: abort beats start; zero-length load
    do_start(4'd5, 1'b0);
    step(); step(); step();
    expect3("ab_at2", 2, 1, 0);
    bus.abort    = 1'b1;
    bus.start    = 1'b1;
    bus.load_val = 4'd9;
    step();
    expect3("ab_abort", 0, 0, 0);
    idle_inputs();
    step();
    expect3("ab_after", 0, 0, 0);
    do_start(4'd0, 1'b1);
    expect3("zero_load", 0, 0, 1);
    step();
    expect3("zero_after", 0, 0, 0);

    // 6a: full-range periodic
    do_start(4'd15, 1'b1);
    expect3("max_load", 15, 1, 0);
    for (int i = 14; i >= 1; i--) begin
      step();
      expect3("max_dec", i, 1, 0);
    end
    step(); expect3("max_reload", 15, 1, 1);
    step(); expect3("max_14", 14, 1, 0);

    // 6b: V=1 periodic, done every cycle
    do_start(4'd1, 1'b1);
    expect3("one_load", 1, 1, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      expect3("one_tick", 1, 1, 1);
    end
    bus.abort = 1'b1;
    step();
    expect3("one_abort", 0, 0, 0);
    idle_inputs();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
